// File: rtl/event_counter.sv
// Up/down event counter fed by two asynchronous pulse inputs, with a programmable
// upper limit, wrap-or-saturate behaviour at the limits and a synchronous load.
module event_counter #(
    parameter int WIDTH       = 8,
    parameter int MODE_SAT    = 0,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_DETECT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             impulse_up,
    input  logic             impulse_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);
    // In edge mode the chains reset high so an input held through reset is not an event.
    localparam logic             SYNC_RST = (EDGE_DETECT != 0) ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_up_q;
    logic [SYNC_STAGES-1:0] sync_dn_q;
    logic                   prev_up_q;
    logic                   prev_dn_q;
    logic                   ev_up_s;
    logic                   ev_dn_s;
    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   wrap_q;
    logic                   wrap_d;

    // Synchroniser chains plus one-cycle history of their outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_up_q <= {SYNC_STAGES{SYNC_RST}};
            sync_dn_q <= {SYNC_STAGES{SYNC_RST}};
            prev_up_q <= SYNC_RST;
            prev_dn_q <= SYNC_RST;
        end else begin
            sync_up_q[0] <= impulse_up;
            sync_dn_q[0] <= impulse_down;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_up_q[i] <= sync_up_q[i-1];
                sync_dn_q[i] <= sync_dn_q[i-1];
            end
            prev_up_q <= sync_up_q[SYNC_STAGES-1];
            prev_dn_q <= sync_dn_q[SYNC_STAGES-1];
        end
    end

    assign ev_up_s = (EDGE_DETECT != 0) ? (sync_up_q[SYNC_STAGES-1] & ~prev_up_q)
                                        : sync_up_q[SYNC_STAGES-1];
    assign ev_dn_s = (EDGE_DETECT != 0) ? (sync_dn_q[SYNC_STAGES-1] & ~prev_dn_q)
                                        : sync_dn_q[SYNC_STAGES-1];

    // Next count and wrap flag; limit compares come first so nothing overflows WIDTH
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            if (load_value > max_value) begin
                count_d = max_value;
            end else begin
                count_d = load_value;
            end
        end else if (ev_up_s && ev_dn_s) begin
            count_d = count_q;
        end else if (ev_up_s) begin
            if (count_q < max_value) begin
                count_d = count_q + ONE;
            end else begin
                wrap_d  = 1'b1;
                count_d = (MODE_SAT != 0) ? max_value : ZERO;
            end
        end else if (ev_dn_s) begin
            if (count_q == ZERO) begin
                wrap_d  = 1'b1;
                count_d = (MODE_SAT != 0) ? ZERO : max_value;
            end else if (count_q > max_value) begin
                count_d = max_value;
            end else begin
                count_d = count_q - ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and wrap pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_max  = (count_q == max_value);
    assign at_zero = (count_q == ZERO);

endmodule

// File: tb/tb_event_counter.sv
// Bench for event_counter: three configurations (wrap/edge, saturate/edge, wrap/level)
// share one stimulus stream and are checked every cycle against a sample-history model.
module tb_event_counter;
    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic       imp_up;
    logic       imp_dn;
    logic       ld;
    logic [7:0] lv;
    logic [7:0] mx;
    logic [7:0] cnt0, cnt1, cnt2;
    logic       wr0, wr1, wr2;
    logic       am0, am1, am2;
    logic       az0, az1, az2;

    int tests = 0;
    int fails = 0;

    event_counter #(.WIDTH(8), .MODE_SAT(0), .SYNC_STAGES(S), .EDGE_DETECT(1)) dut_wrap (
        .clk(clk), .rst(rst), .impulse_up(imp_up), .impulse_down(imp_dn), .load(ld),
        .load_value(lv), .max_value(mx), .count(cnt0), .wrap(wr0), .at_max(am0), .at_zero(az0));
    event_counter #(.WIDTH(8), .MODE_SAT(1), .SYNC_STAGES(S), .EDGE_DETECT(1)) dut_sat (
        .clk(clk), .rst(rst), .impulse_up(imp_up), .impulse_down(imp_dn), .load(ld),
        .load_value(lv), .max_value(mx), .count(cnt1), .wrap(wr1), .at_max(am1), .at_zero(az1));
    event_counter #(.WIDTH(8), .MODE_SAT(0), .SYNC_STAGES(S), .EDGE_DETECT(0)) dut_lvl (
        .clk(clk), .rst(rst), .impulse_up(imp_up), .impulse_down(imp_dn), .load(ld),
        .load_value(lv), .max_value(mx), .count(cnt2), .wrap(wr2), .at_max(am2), .at_zero(az2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts per instance plus the log of input samples taken at each edge.
    // Bit k of a log entry is what instance k sees for that sample.
    int         m_cnt [3];
    bit         m_wrap[3];
    logic [2:0] up_log[$];
    logic [2:0] dn_log[$];

    function automatic bit is_edge(input int k);
        return (k != 2);
    endfunction

    function automatic bit is_sat(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        up_log.delete();
        dn_log.delete();
        for (int j = 0; j <= S; j++) begin
            up_log.push_back(3'b011);
            dn_log.push_back(3'b011);
        end
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
        end
    endtask

    // An input sampled at edge n produces its event at edge n+S.
    task automatic model_step();
        int  sz;
        int  c;
        int  lim;
        bit  eu, ed, w;
        sz  = up_log.size();
        lim = int'(mx);
        for (int k = 0; k < 3; k++) begin
            eu = is_edge(k) ? (up_log[sz-S][k] && !up_log[sz-S-1][k]) : up_log[sz-S][k];
            ed = is_edge(k) ? (dn_log[sz-S][k] && !dn_log[sz-S-1][k]) : dn_log[sz-S][k];
            c  = m_cnt[k];
            w  = 1'b0;
            if (ld) begin
                c = (int'(lv) < lim) ? int'(lv) : lim;
            end else if (eu && ed) begin
                c = m_cnt[k];
            end else if (eu) begin
                if (c < lim) c = c + 1;
                else begin w = 1'b1; c = is_sat(k) ? lim : 0; end
            end else if (ed) begin
                if (c == 0) begin w = 1'b1; c = is_sat(k) ? 0 : lim; end
                else if (c > lim) c = lim;
                else c = c - 1;
            end
            m_cnt[k]  = c;
            m_wrap[k] = w;
        end
        up_log.push_back({3{imp_up}});
        dn_log.push_back({3{imp_dn}});
        if (up_log.size() > 8) begin
            void'(up_log.pop_front());
            void'(dn_log.pop_front());
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] c, input logic w, input logic am, input logic az);
        chk("count", k, 32'(c), 32'(m_cnt[k]));
        chk("wrap", k, 32'(w), 32'(m_wrap[k]));
        chk("at_max", k, 32'(am), 32'(m_cnt[k] == int'(mx)));
        chk("at_zero", k, 32'(az), 32'(m_cnt[k] == 0));
    endtask

    task automatic check_all();
        check_inst(0, cnt0, wr0, am0, az0);
        check_inst(1, cnt1, wr1, am1, az1);
        check_inst(2, cnt2, wr2, am2, az2);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        bit up;
        bit dn;
        bit ld;
        int lv;
        int mx;
        int exp_w;
        bit wr_w;
        int exp_s;
        bit wr_s;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit up, input bit dn, input bit l, input int v, input int m,
                       input int ew, input bit eww, input int es, input bit ews);
        vec_t r;
        r = '{up, dn, l, v, m, ew, eww, es, ews};
        vt.push_back(r);
    endtask

    initial begin
        // Wrap (inst 0) and saturate (inst 1) expectations, one pulse or load per row
        add(0, 0, 1, 0, 9, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) add(1, 0, 0, 0, 9, k, 0, k, 0);
        add(1, 0, 0, 0, 9, 0, 1, 9, 1);
        add(0, 1, 0, 0, 9, 9, 1, 8, 0);
        add(0, 0, 1, 0, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, 5, k, 0, k, 0);
        add(1, 0, 0, 0, 5, 0, 1, 5, 1);
        add(1, 0, 0, 0, 5, 1, 0, 5, 1);
        add(1, 0, 0, 0, 5, 2, 0, 5, 1);
        add(0, 1, 0, 0, 5, 1, 0, 4, 0);
        add(0, 1, 0, 0, 5, 0, 0, 3, 0);
        add(0, 1, 0, 0, 5, 5, 1, 2, 0);
        add(0, 1, 0, 0, 5, 4, 0, 1, 0);
        add(0, 1, 0, 0, 5, 3, 0, 0, 0);
        add(0, 1, 0, 0, 5, 2, 0, 0, 1);
        add(0, 1, 0, 0, 5, 1, 0, 0, 1);
        add(0, 0, 1, 200, 100, 100, 0, 100, 0);
        add(0, 0, 1, 9, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1);

        // Reset with impulse_up held high through deassertion
        rst = 1'b1; imp_up = 1'b1; imp_dn = 1'b0; ld = 1'b0; lv = 8'd0; mx = 8'd255;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_cnt", 0, 32'(cnt0), 32'd0);
            chk("held_wrap", 0, 32'(wr0), 32'd0);
        end
        imp_up = 1'b0; tick(); tick();
        imp_up = 1'b1;
        tick(); chk("latency_e0", 0, 32'(cnt0), 32'd0);
        tick(); chk("latency_e1", 0, 32'(cnt0), 32'd0);
        tick(); chk("latency_e2", 0, 32'(cnt0), 32'd1);
        imp_up = 1'b0;

        // Table: wrap and saturate behaviour, load clamping, max_value == 0
        for (int i = 0; i < vt.size(); i++) begin
            imp_up = vt[i].up; imp_dn = vt[i].dn; ld = vt[i].ld;
            lv = 8'(vt[i].lv); mx = 8'(vt[i].mx);
            tick();
            imp_up = 1'b0; imp_dn = 1'b0; ld = 1'b0;
            tick(); tick();
            chk("tbl_cnt_wrapmode", i, 32'(cnt0), 32'(vt[i].exp_w));
            chk("tbl_wrap_wrapmode", i, 32'(wr0), 32'(vt[i].wr_w));
            chk("tbl_cnt_satmode", i, 32'(cnt1), 32'(vt[i].exp_s));
            chk("tbl_wrap_satmode", i, 32'(wr1), 32'(vt[i].wr_s));
        end

        // Load wins over an event arriving in the same cycle
        ld = 1'b1; lv = 8'd3; mx = 8'd100; tick(); ld = 1'b0; tick();
        imp_up = 1'b1; tick(); imp_up = 1'b0; tick();
        ld = 1'b1; lv = 8'd200; tick(); ld = 1'b0;
        chk("load_prio_cnt", 0, 32'(cnt0), 32'd100);
        chk("load_prio_wrap", 0, 32'(wr0), 32'd0);
        chk("load_prio_cnt", 1, 32'(cnt1), 32'd100);
        tick(); tick();
        chk("load_drop_hold", 0, 32'(cnt0), 32'd100);

        // Simultaneous up and down edges
        ld = 1'b1; lv = 8'd50; tick(); ld = 1'b0;
        imp_up = 1'b1; imp_dn = 1'b1; tick(); imp_up = 1'b0; imp_dn = 1'b0; tick(); tick();
        chk("updn_cnt", 0, 32'(cnt0), 32'd50);
        chk("updn_wrap", 0, 32'(wr0), 32'd0);
        chk("updn_cnt", 2, 32'(cnt2), 32'd50);

        // Level mode counts every high cycle, edge mode only the rising edge
        imp_up = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        imp_up = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("level_cnt", 2, 32'(cnt2), 32'd54);
        chk("edge_cnt", 0, 32'(cnt0), 32'd51);
        chk("edge_cnt", 1, 32'(cnt1), 32'd51);

        // max_value lowered below the count, then one down event
        ld = 1'b1; lv = 8'd50; tick(); ld = 1'b0;
        mx = 8'd20; tick();
        imp_dn = 1'b1; tick(); imp_dn = 1'b0; tick(); tick();
        chk("lowered_max_cnt", 0, 32'(cnt0), 32'd20);
        chk("lowered_max_wrap", 0, 32'(wr0), 32'd0);
        chk("lowered_max_cnt", 1, 32'(cnt1), 32'd20);
        chk("lowered_max_cnt", 2, 32'(cnt2), 32'd20);

        // Asynchronous reset between edges with an event in the synchroniser
        ld = 1'b1; lv = 8'd7; tick(); ld = 1'b0;
        imp_up = 1'b1; tick(); imp_up = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_cnt", 0, 32'(cnt0), 32'd0);
        chk("async_rst_cnt", 1, 32'(cnt1), 32'd0);
        chk("async_rst_cnt", 2, 32'(cnt2), 32'd0);
        chk("async_rst_zero", 0, 32'(az0), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_cnt", 0, 32'(cnt0), 32'd0);
        chk("post_rst_cnt", 2, 32'(cnt2), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            imp_up = ($urandom_range(0, 2) == 0);
            imp_dn = ($urandom_range(0, 2) == 0);
            ld     = ($urandom_range(0, 24) == 0);
            lv     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: mx = 8'd0;
                    1: mx = 8'd1;
                    2: mx = 8'd255;
                    default: mx = 8'($urandom_range(2, 254));
                endcase
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
